// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter - round-robin sharing of one memory burst port between icache refills
// and dcache refills/writebacks, with read-beat routing and core stall generation.
module mem_refill_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wnext,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

  state_t             state, state_nxt;
  logic               owner, owner_nxt;
  logic               last_gnt, last_gnt_nxt;
  logic               we_q, we_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_IC;
      last_gnt <= OWN_DC;
      we_q     <= 1'b0;
      addr_q   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last_gnt <= last_gnt_nxt;
      we_q     <= we_nxt;
      addr_q   <= addr_nxt;
      count    <= count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    last_gnt_nxt  = last_gnt;
    we_nxt        = we_q;
    addr_nxt      = addr_q;
    count_nxt     = count;
    grant         = OWN_IC;
    ic_rvalid     = 1'b0;
    ic_done       = 1'b0;
    dc_wnext      = 1'b0;
    dc_rvalid     = 1'b0;
    dc_done       = 1'b0;
    rdata         = '0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;

    case (state)
      IDLE: begin
        if (ic_req || dc_req) begin
          // On a tie the side that did not win last time goes first.
          grant     = (ic_req && dc_req) ? ~last_gnt : dc_req;
          owner_nxt = grant;
          addr_nxt  = (grant == OWN_DC) ? dc_addr : ic_addr;
          we_nxt    = (grant == OWN_DC) && dc_we;
          state_nxt = CMD;
        end
      end
      CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = we_q;
        mem_cmd_addr  = addr_q;
        if (mem_cmd_ready) begin
          count_nxt = '0;
          state_nxt = we_q ? WDATA : RDATA;
        end
      end
      WDATA: begin
        mem_wvalid = 1'b1;
        mem_wdata  = dc_wdata;
        if (mem_wready) begin
          dc_wnext  = 1'b1;
          count_nxt = count + 1'b1;
          if (count == LAST_BEAT) state_nxt = DONE;
        end
      end
      RDATA: begin
        rdata     = mem_rdata;
        ic_rvalid = mem_rvalid && (owner == OWN_IC);
        dc_rvalid = mem_rvalid && (owner == OWN_DC);
        if (mem_rvalid) begin
          count_nxt = count + 1'b1;
          if (count == LAST_BEAT) state_nxt = DONE;
        end
      end
      DONE: begin
        ic_done      = (owner == OWN_IC);
        dc_done      = (owner == OWN_DC);
        last_gnt_nxt = owner;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst_n so the stall is also low while reset is held.
  assign stall = rst_n && (ic_req || dc_req || (state != IDLE));

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter - directed self-checking bench for mem_refill_arbiter.
module tb_mem_refill_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_rvalid;
  logic        ic_done;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic        dc_wnext;
  logic        dc_rvalid;
  logic        dc_done;
  logic [31:0] rdata;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic        mem_cmd_we;
  logic [31:0] mem_cmd_addr;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall;

  int total = 0;
  int bad   = 0;

  mem_refill_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wnext(dc_wnext), .dc_rvalid(dc_rvalid), .dc_done(dc_done), .rdata(rdata),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] pat;
    int         n;
    logic       exp_dc;
    logic       reraise_ic;
    logic       reraise_dc;

    rst_n = 1'b0; ic_req = 1'b1; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
    dc_addr = '0; dc_wdata = '0; mem_cmd_ready = 1'b0; mem_wready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_cmd_valid", mem_cmd_valid, 0);
    tick();
    tick();
    chk("rst_hold_cmd_valid", mem_cmd_valid, 0);
    chk("rst_hold_ic_done", ic_done, 0);
    ic_req = 1'b0;
    rst_n  = 1'b1;
    tick();

    // 1: icache refill with gapped read beats
    ic_addr = 32'h100; ic_req = 1'b1;
    #1;
    chk("t1_stall_req", stall, 1);
    chk("t1_idle_cmd_valid", mem_cmd_valid, 0);
    tick();
    chk("t1_cmd_valid", mem_cmd_valid, 1);
    chk("t1_cmd_addr", mem_cmd_addr, 32'h100);
    chk("t1_cmd_we", mem_cmd_we, 0);
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    pat = 6'b101101;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      mem_rvalid = pat[i];
      mem_rdata  = 32'hA0 + i;
      #1;
      chk("t1_ic_rvalid", ic_rvalid, pat[i]);
      chk("t1_dc_rvalid", dc_rvalid, 0);
      if (pat[i]) begin
        n++;
        chk("t1_rdata", rdata, 32'hA0 + i);
      end
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    chk("t1_beats", n, 4);
    chk("t1_ic_done", ic_done, 1);
    chk("t1_dc_done", dc_done, 0);
    tick();
    ic_req = 1'b0;
    #1;
    chk("t1_ic_done_pulse", ic_done, 0);
    chk("t1_stall_idle", stall, 0);

    // 2: dcache writeback with write backpressure
    dc_addr = 32'h2000; dc_we = 1'b1; dc_wdata = 32'h1111_0000; dc_req = 1'b1;
    tick();
    chk("t2_cmd_we", mem_cmd_we, 1);
    chk("t2_cmd_addr", mem_cmd_addr, 32'h2000);
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_wvalid_stalled", mem_wvalid, 1);
      chk("t2_wdata_stalled", mem_wdata, 32'h1111_0000);
      chk("t2_wnext_stalled", dc_wnext, 0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      dc_wdata   = 32'h1111_0000 + k;
      mem_wready = 1'b1;
      #1;
      chk("t2_wdata", mem_wdata, 32'h1111_0000 + k);
      chk("t2_wnext", dc_wnext, 1);
      chk("t2_dc_done_early", dc_done, 0);
      tick();
    end
    mem_wready = 1'b0;
    #1;
    chk("t2_dc_done", dc_done, 1);
    chk("t2_wvalid_done", mem_wvalid, 0);
    tick();
    dc_req = 1'b0; dc_we = 1'b0;
    #1;
    chk("t2_dc_done_pulse", dc_done, 0);

    // 3: simultaneous requests, alternating grants
    ic_addr = 32'h300; dc_addr = 32'h400; ic_req = 1'b1; dc_req = 1'b1;
    reraise_ic = 1'b0; reraise_dc = 1'b0;
    #1;
    chk("t3_stall_start", stall, 1);
    for (int r = 0; r < 4; r++) begin
      exp_dc = (r % 2) == 1;
      tick();
      if (reraise_ic) ic_req = 1'b1;
      if (reraise_dc) dc_req = 1'b1;
      #1;
      chk("t3_cmd_valid", mem_cmd_valid, 1);
      chk("t3_grant_addr", mem_cmd_addr, exp_dc ? 32'h400 : 32'h300);
      chk("t3_stall_cmd", stall, 1);
      mem_cmd_ready = 1'b1;
      tick();
      mem_cmd_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h3000 + r * 16 + b;
        #1;
        chk("t3_ic_rvalid", ic_rvalid, !exp_dc);
        chk("t3_dc_rvalid", dc_rvalid, exp_dc);
        chk("t3_stall_data", stall, 1);
        tick();
      end
      mem_rvalid = 1'b0;
      #1;
      chk("t3_ic_done", ic_done, !exp_dc);
      chk("t3_dc_done", dc_done, exp_dc);
      tick();
      if (exp_dc) dc_req = 1'b0; else ic_req = 1'b0;
      reraise_ic = !exp_dc;
      reraise_dc = exp_dc;
      if (r == 3) begin
        ic_req = 1'b0; dc_req = 1'b0;
      end
      #1;
      chk("t3_gap_cmd_valid", mem_cmd_valid, 0);
      if (r < 3) chk("t3_stall_gap", stall, 1);
    end

    // 4: command backpressure, address change and stray read beats ignored
    dc_addr = 32'h5000; dc_we = 1'b0; dc_req = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      dc_addr = 32'h6000; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0 + i;
      #1;
      chk("t4_cmd_valid", mem_cmd_valid, 1);
      chk("t4_cmd_addr", mem_cmd_addr, 32'h5000);
      chk("t4_cmd_we", mem_cmd_we, 0);
      chk("t4_dc_rvalid_cmd", dc_rvalid, 0);
      tick();
    end
    mem_rvalid = 1'b0; mem_cmd_ready = 1'b1;
    #1;
    chk("t4_cmd_valid_accept", mem_cmd_valid, 1);
    tick();
    mem_cmd_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hD0 + b;
      #1;
      chk("t4_dc_rvalid", dc_rvalid, 1);
      chk("t4_rdata", rdata, 32'hD0 + b);
      chk("t4_dc_done_early", dc_done, 0);
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    chk("t4_dc_done", dc_done, 1);
    tick();
    dc_req = 1'b0;

    // 5: reset in the middle of a read burst
    ic_addr = 32'h700; ic_req = 1'b1;
    tick();
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h70 + b;
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h72;
    #1;
    chk("t5_ic_rvalid_pre", ic_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ic_rvalid", ic_rvalid, 0);
    chk("t5_rst_rdata", rdata, 0);
    chk("t5_rst_stall", stall, 0);
    chk("t5_rst_ic_done", ic_done, 0);
    tick();
    chk("t5_rst_hold_ic_done", ic_done, 0);
    chk("t5_rst_hold_cmd_valid", mem_cmd_valid, 0);
    rst_n = 1'b1; mem_rvalid = 1'b0;
    dc_addr = 32'h800; dc_we = 1'b0; dc_req = 1'b1;
    #1;
    chk("t5_idle_ic_rvalid", ic_rvalid, 0);
    chk("t5_stall_tie", stall, 1);
    tick();
    chk("t5_tie_grant_ic", mem_cmd_addr, 32'h700);
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h80 + b;
      #1;
      chk("t5_ic_rvalid", ic_rvalid, 1);
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    chk("t5_ic_done", ic_done, 1);
    tick();
    ic_req = 1'b0;

    // 6: dcache drops its request after the first refill beat
    tick();
    chk("t6_cmd_addr", mem_cmd_addr, 32'h800);
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hE0;
    #1;
    chk("t6_dc_rvalid_first", dc_rvalid, 1);
    tick();
    dc_req = 1'b0;
    for (int b = 1; b < 4; b++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hE0 + b;
      #1;
      chk("t6_dc_rvalid", dc_rvalid, 1);
      chk("t6_ic_rvalid", ic_rvalid, 0);
      chk("t6_rdata", rdata, 32'hE0 + b);
      chk("t6_stall", stall, 1);
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    chk("t6_dc_done", dc_done, 1);
    tick();
    chk("t6_dc_done_pulse", dc_done, 0);
    chk("t6_stall_idle", stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
